// File: rtl/modmul_interleaved.sv
// Modular multiplier: result = (in_a * in_b) mod in_m by MSB-first double-and-add.
// All additions are delegated to an external modadder via add_start/add_done.
module modmul_interleaved #(
  parameter int unsigned WIDTH = 381,
  parameter int unsigned NBITS = 381,
  parameter int unsigned CW    = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_m,
  output logic             add_subtract,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DBL_REQ  = 3'd1,
    DBL_WAIT = 3'd2,
    ADD_REQ  = 3'd3,
    ADD_WAIT = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             add_start_q, add_start_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] add_m_q, add_m_d;

  // Multiplier bits above NBITS are never scanned.
  if (NBITS < WIDTH) begin : g_unused_b
    logic unused_b_hi;
    assign unused_b_hi = ^in_b[WIDTH-1:NBITS];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_m_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_m_q     <= add_m_d;
    end
  end

  // Next-state and next-output logic. b_q is shifted left as bits are consumed,
  // so the current multiplier bit is always b_q[NBITS-1].
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    acc_d       = acc_q;
    i_d         = i_q;
    result_d    = result_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    add_start_d = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_m_d     = add_m_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b[NBITS-1:0];
          m_d     = in_m;
          acc_d   = '0;
          i_d     = CW'(NBITS - 1);
          busy_d  = 1'b1;
          state_d = DBL_REQ;
        end
      end
      DBL_REQ: state_d = DBL_WAIT;
      DBL_WAIT: begin
        if (add_done) begin
          acc_d = add_result;
          if (b_q[NBITS-1]) begin
            state_d = ADD_REQ;
          end else if (i_q == '0) begin
            state_d = FIN;
          end else begin
            i_d     = i_q - CW'(1);
            b_d     = b_q << 1;
            state_d = DBL_REQ;
          end
        end
      end
      ADD_REQ: state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (add_done) begin
          acc_d = add_result;
          if (i_q == '0) begin
            state_d = FIN;
          end else begin
            i_d     = i_q - CW'(1);
            b_d     = b_q << 1;
            state_d = DBL_REQ;
          end
        end
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Load adder operands and the request pulse on entry to a REQ state,
    // so the registered pulse is high exactly during the REQ cycle.
    if (state_d == DBL_REQ) begin
      add_start_d = 1'b1;
      add_a_d     = acc_d;
      add_b_d     = acc_d;
      add_m_d     = m_d;
    end else if (state_d == ADD_REQ) begin
      add_start_d = 1'b1;
      add_a_d     = acc_d;
      add_b_d     = a_d;
      add_m_d     = m_d;
    end
  end

  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign add_start    = add_start_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_m        = add_m_q;
  assign add_subtract = 1'b0;

endmodule
